// File: rtl/color_bbox_overlay_if.sv
// Pixel/sideband bundle between the highlight stage, the bbox overlay and VGA out.
// Stats fields report the last complete frame.
interface color_bbox_overlay_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int CW = 19
);
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [23:0]   pass_in;
    logic          box_en;
    logic [7:0]    outR;
    logic [7:0]    outG;
    logic [7:0]    outB;
    logic [23:0]   pass_thru;
    logic [CW-1:0] pix_count;
    logic [XW-1:0] min_x;
    logic [XW-1:0] max_x;
    logic [YW-1:0] min_y;
    logic [YW-1:0] max_y;
    logic          box_valid;
    logic          frame_done;

    modport master (
        output r, g, b, pass_in, box_en,
        input  outR, outG, outB, pass_thru, pix_count,
        input  min_x, max_x, min_y, max_y, box_valid, frame_done
    );

    modport slave (
        input  r, g, b, pass_in, box_en,
        output outR, outG, outB, pass_thru, pix_count,
        output min_x, max_x, min_y, max_y, box_valid, frame_done
    );
endinterface

// File: rtl/color_bbox_overlay.sv
// Per-frame highlighted-pixel count and bounding box, latched at vsync,
// with optional box overlay drawn on the live video (1-cycle latency).
module color_bbox_overlay #(
    parameter int          XW        = 10,
    parameter int          YW        = 10,
    parameter int          CW        = 19,
    parameter int          MIN_PIX   = 64,
    parameter logic [23:0] BOX_COLOR = 24'hFF00FF
) (
    input logic               clk,
    input logic               rst,
    color_bbox_overlay_if.slave bus
);
    logic [23:0]   pass_q;
    logic [23:0]   pix_q;
    logic [23:0]   pix_d;
    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] minx_q, maxx_q, minx_d, maxx_d;
    logic [YW-1:0] miny_q, maxy_q, miny_d, maxy_d;
    logic [CW-1:0] st_cnt;
    logic [XW-1:0] st_minx, st_maxx;
    logic [YW-1:0] st_miny, st_maxy;
    logic          st_valid;
    logic          done_q;
    logic          primed_q;
    logic          blank, fs, bfall, hl;
    logic          in_x, in_y, hit;

    always_comb begin
        blank = bus.pass_in[0];
        fs    = pass_q[2] & ~bus.pass_in[2];
        bfall = pass_q[0] & ~blank;
        hl    = blank & ~((bus.r == bus.g) & (bus.g == bus.b));
        // a pixel coincident with frame start belongs to the new frame at (0,0)
        px    = fs ? '0 : x_q;
        py    = fs ? '0 : y_q;

        x_d = x_q;
        y_d = y_q;
        if (fs) begin
            x_d = '0;
            y_d = '0;
        end else if (bfall) begin
            x_d = '0;
            if (y_q != '1)
                y_d = y_q + 1'b1;
        end
        if (blank && (px != '1))
            x_d = px + 1'b1;

        cnt_d  = fs ? '0 : cnt_q;
        minx_d = fs ? '1 : minx_q;
        maxx_d = fs ? '0 : maxx_q;
        miny_d = fs ? '1 : miny_q;
        maxy_d = fs ? '0 : maxy_q;
        if (hl) begin
            if (cnt_d != '1)
                cnt_d = cnt_d + 1'b1;
            if (px < minx_d)
                minx_d = px;
            if (px > maxx_d)
                maxx_d = px;
            if (py < miny_d)
                miny_d = py;
            if (py > maxy_d)
                maxy_d = py;
        end

        // overlay always draws the latched box of the previous frame
        in_x = (px >= st_minx) && (px <= st_maxx);
        in_y = (py >= st_miny) && (py <= st_maxy);
        hit  = bus.box_en & st_valid & blank &
               ((in_y & ((px == st_minx) | (px == st_maxx))) |
                (in_x & ((py == st_miny) | (py == st_maxy))));
        pix_d = hit ? BOX_COLOR : {bus.r, bus.g, bus.b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q   <= '0;
            pix_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            minx_q   <= '1;
            maxx_q   <= '0;
            miny_q   <= '1;
            maxy_q   <= '0;
            st_cnt   <= '0;
            st_minx  <= '1;
            st_maxx  <= '0;
            st_miny  <= '1;
            st_maxy  <= '0;
            st_valid <= 1'b0;
            done_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            pass_q <= bus.pass_in;
            pix_q  <= pix_d;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            minx_q <= minx_d;
            maxx_q <= maxx_d;
            miny_q <= miny_d;
            maxy_q <= maxy_d;
            done_q <= 1'b0;
            if (fs) begin
                primed_q <= 1'b1;
                // the first frame start after reset only primes
                if (primed_q) begin
                    st_cnt   <= cnt_q;
                    st_minx  <= minx_q;
                    st_maxx  <= maxx_q;
                    st_miny  <= miny_q;
                    st_maxy  <= maxy_q;
                    st_valid <= (cnt_q >= CW'(MIN_PIX));
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.outR       = pix_q[23:16];
    assign bus.outG       = pix_q[15:8];
    assign bus.outB       = pix_q[7:0];
    assign bus.pass_thru  = pass_q;
    assign bus.pix_count  = st_cnt;
    assign bus.min_x      = st_minx;
    assign bus.max_x      = st_maxx;
    assign bus.min_y      = st_miny;
    assign bus.max_y      = st_maxy;
    assign bus.box_valid  = st_valid;
    assign bus.frame_done = done_q;
endmodule
